// File: rtl/mor1kx_rf_banked_pkg.sv
// -----------------------------------------------------------------------------
// mor1kx_rf_banked_pkg
// Shared definitions for the banked register file:
//   - ctx_state_e  : context-engine state encoding (IDLE / COPY / DONE)
//   - bank_w()     : bank-select width, never narrower than one bit
//   - MOR1KX_RF_TAP_ADDR : slice of a packed tap-address list (tap 0 in LSBs)
// No ports.
// -----------------------------------------------------------------------------
`ifndef MOR1KX_RF_TAP_ADDR
`define MOR1KX_RF_TAP_ADDR(taps, t, aw) taps[(t)*(aw) +: (aw)]
`endif

package mor1kx_rf_banked_pkg;

  typedef enum logic [1:0] {
    CTX_IDLE = 2'd0,
    CTX_COPY = 2'd1,
    CTX_DONE = 2'd2
  } ctx_state_e;

  // A single-bank build still carries a one-bit bank index.
  function automatic int bank_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mor1kx_rf_ctx_fsm.sv
// -----------------------------------------------------------------------------
// mor1kx_rf_ctx_fsm
// Context-switch engine for the banked register file. Accepts a switch request
// in IDLE, optionally walks every GPR index to clone the active bank into the
// target bank, then commits the new active bank and pulses ack for one cycle.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   ctx_req_i       request strobe (ignored unless IDLE)
//   ctx_clone_i     1 = clone active bank into target before switching
//   ctx_target_i    target bank
//   ctx_busy_o      clone walk in progress
//   ctx_ack_o       one-cycle completion pulse
//   active_bank_o   current bank
//   copy_en_o       storage should copy copy_idx_o from active into copy_dst_o
//   copy_dst_o      clone destination bank (also the write-mirror bank)
//   copy_idx_o      word being copied this cycle
// -----------------------------------------------------------------------------
module mor1kx_rf_ctx_fsm
  import mor1kx_rf_banked_pkg::*;
#(
  parameter int ADDR_W    = 5,
  parameter int NUM_BANKS = 2,
  parameter int BANK_W    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ctx_req_i,
  input  logic              ctx_clone_i,
  input  logic [BANK_W-1:0] ctx_target_i,
  output logic              ctx_busy_o,
  output logic              ctx_ack_o,
  output logic [BANK_W-1:0] active_bank_o,
  output logic              copy_en_o,
  output logic [BANK_W-1:0] copy_dst_o,
  output logic [ADDR_W-1:0] copy_idx_o
);

  ctx_state_e        state_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic [BANK_W-1:0] tgt_reg;
  logic [BANK_W-1:0] active_reg;
  logic              busy_reg;
  logic              ack_reg;
  logic              target_valid;
  logic              clone_needed;

  // A target index beyond the configured banks completes as a no-op switch.
  assign target_valid = (int'(ctx_target_i) < NUM_BANKS);
  // Cloning a bank onto itself is pointless, so that case is a plain switch.
  assign clone_needed = (NUM_BANKS > 1) && ctx_clone_i && target_valid &&
                        (ctx_target_i != active_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= CTX_IDLE;
      idx_reg    <= '0;
      tgt_reg    <= '0;
      active_reg <= '0;
      busy_reg   <= 1'b0;
      ack_reg    <= 1'b0;
    end else begin
      ack_reg <= 1'b0;
      case (state_reg)
        CTX_IDLE: begin
          if (ctx_req_i) begin
            idx_reg <= '0;
            if (clone_needed) begin
              tgt_reg   <= ctx_target_i;
              busy_reg  <= 1'b1;
              state_reg <= CTX_COPY;
            end else begin
              if (target_valid)
                active_reg <= ctx_target_i;
              ack_reg   <= 1'b1;
              state_reg <= CTX_DONE;
            end
          end
        end
        CTX_COPY: begin
          idx_reg <= idx_reg + 1'b1;
          if (&idx_reg) begin
            active_reg <= tgt_reg;
            busy_reg   <= 1'b0;
            ack_reg    <= 1'b1;
            state_reg  <= CTX_DONE;
          end
        end
        CTX_DONE: state_reg <= CTX_IDLE;
        default:  state_reg <= CTX_IDLE;
      endcase
    end
  end

  assign ctx_busy_o    = busy_reg;
  assign ctx_ack_o     = ack_reg;
  assign active_bank_o = active_reg;
  assign copy_en_o     = busy_reg;
  assign copy_dst_o    = tgt_reg;
  assign copy_idx_o    = idx_reg;

endmodule

// File: rtl/mor1kx_rf_banked.sv
// -----------------------------------------------------------------------------
// mor1kx_rf_banked
// Flop-based GPR file with NUM_BANKS shadow contexts, NUM_READ_PORTS held read
// ports, optional hard-zero r0, a hardware bank-clone engine and tap outputs
// for the shadow-stack monitor.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   rd_en_i         latch rd_adr_i into the held read addresses
//   rd_adr_i        packed read indices (port 0 in LSBs)
//   rd_dat_o        packed registered read data
//   wr_en_i, wr_adr_i, wr_dat_i   writeback into the active bank
//   ctx_req_i, ctx_clone_i, ctx_target_i   context switch / clone request
//   ctx_busy_o, ctx_ack_o, active_bank_o   context engine status
//   tap_dat_o       active-bank value of each tap register
//   tap_upd_o       per tap: that register is written this cycle
// -----------------------------------------------------------------------------
module mor1kx_rf_banked
  import mor1kx_rf_banked_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter int NUM_READ_PORTS       = 2,
  parameter int NUM_BANKS            = 2,
  parameter int NUM_TAPS             = 2,
  parameter logic [NUM_TAPS*OPTION_RF_ADDR_WIDTH-1:0] TAP_ADDRS = {5'd20, 5'd9},
  parameter int ZERO_R0              = 1
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           rd_en_i,
  input  logic [NUM_READ_PORTS*OPTION_RF_ADDR_WIDTH-1:0] rd_adr_i,
  output logic [NUM_READ_PORTS*OPTION_OPERAND_WIDTH-1:0] rd_dat_o,
  input  logic                                           wr_en_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0]                wr_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]                wr_dat_i,
  input  logic                                           ctx_req_i,
  input  logic                                           ctx_clone_i,
  input  logic [bank_w(NUM_BANKS)-1:0]                   ctx_target_i,
  output logic                                           ctx_busy_o,
  output logic                                           ctx_ack_o,
  output logic [bank_w(NUM_BANKS)-1:0]                   active_bank_o,
  output logic [NUM_TAPS*OPTION_OPERAND_WIDTH-1:0]       tap_dat_o,
  output logic [NUM_TAPS-1:0]                            tap_upd_o
);

  localparam int W      = OPTION_OPERAND_WIDTH;
  localparam int AW     = OPTION_RF_ADDR_WIDTH;
  localparam int WORDS  = 2 ** AW;
  localparam int BANK_W = bank_w(NUM_BANKS);

  logic [W-1:0]      mem [NUM_BANKS][WORDS];
  logic [BANK_W-1:0] active_bank;
  logic              copy_en;
  logic [BANK_W-1:0] copy_dst;
  logic [AW-1:0]     copy_idx;
  logic [W-1:0]      copy_src;
  logic              wr_ok;

  mor1kx_rf_ctx_fsm #(
    .ADDR_W    (AW),
    .NUM_BANKS (NUM_BANKS),
    .BANK_W    (BANK_W)
  ) u_ctx_fsm (
    .clk           (clk),
    .rst_n         (rst_n),
    .ctx_req_i     (ctx_req_i),
    .ctx_clone_i   (ctx_clone_i),
    .ctx_target_i  (ctx_target_i),
    .ctx_busy_o    (ctx_busy_o),
    .ctx_ack_o     (ctx_ack_o),
    .active_bank_o (active_bank),
    .copy_en_o     (copy_en),
    .copy_dst_o    (copy_dst),
    .copy_idx_o    (copy_idx)
  );

  assign active_bank_o = active_bank;

  // Writes to a hard-zero r0 are dropped everywhere (storage, bypass, mirror).
  assign wr_ok    = wr_en_i && !((ZERO_R0 != 0) && (wr_adr_i == '0));
  assign copy_src = mem[active_bank][copy_idx];

  // Storage. During a clone, writeback also lands in the destination bank so
  // words already copied stay coherent; the write is applied after the copy
  // so a same-index write overrides the (stale) copied word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int w = 0; w < WORDS; w++)
          mem[b][w] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int w = 0; w < WORDS; w++) begin
          if (copy_en && (copy_dst == BANK_W'(b)) && (copy_idx == AW'(w)))
            mem[b][w] <= copy_src;
          if (wr_ok && (wr_adr_i == AW'(w)) &&
              ((active_bank == BANK_W'(b)) || (copy_en && (copy_dst == BANK_W'(b)))))
            mem[b][w] <= wr_dat_i;
        end
      end
    end
  end

  // Held read ports: data refreshes on rd_en_i, or when writeback hits the
  // held address, so the port never needs a separate last-writeback bypass.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_rd
      logic [AW-1:0] adr_in;
      logic [AW-1:0] held_reg;
      logic [W-1:0]  dat_reg;

      assign adr_in = rd_adr_i[gi*AW +: AW];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          held_reg <= '0;
          dat_reg  <= '0;
        end else if (rd_en_i) begin
          held_reg <= adr_in;
          if ((ZERO_R0 != 0) && (adr_in == '0))
            dat_reg <= '0;
          else if (wr_ok && (wr_adr_i == adr_in))
            dat_reg <= wr_dat_i;
          else
            dat_reg <= mem[active_bank][adr_in];
        end else if (wr_ok && (wr_adr_i == held_reg)) begin
          dat_reg <= wr_dat_i;
        end
      end

      assign rd_dat_o[gi*W +: W] = dat_reg;
    end

    for (gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
      localparam logic [AW-1:0] TAP_ADR = `MOR1KX_RF_TAP_ADDR(TAP_ADDRS, gi, AW);

      assign tap_dat_o[gi*W +: W] = mem[active_bank][TAP_ADR];
      assign tap_upd_o[gi] = wr_en_i && (wr_adr_i == TAP_ADR) &&
                             !((ZERO_R0 != 0) && (TAP_ADR == '0));
    end
  endgenerate

endmodule

// File: tb/tb_mor1kx_rf_banked.sv
// -----------------------------------------------------------------------------
// tb_mor1kx_rf_banked
// Self-checking bench for mor1kx_rf_banked with default parameters.
// -----------------------------------------------------------------------------
module tb_mor1kx_rf_banked;

  localparam int W     = 32;
  localparam int AW    = 5;
  localparam int WORDS = 32;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          rd_en;
  logic [2*AW-1:0] rd_adr;
  logic [2*W-1:0]  rd_dat;
  logic          wr_en;
  logic [AW-1:0] wr_adr;
  logic [W-1:0]  wr_dat;
  logic          ctx_req;
  logic          ctx_clone;
  logic [0:0]    ctx_target;
  logic          ctx_busy;
  logic          ctx_ack;
  logic [0:0]    active_bank;
  logic [2*W-1:0] tap_dat;
  logic [1:0]    tap_upd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mor1kx_rf_banked dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_en_i       (rd_en),
    .rd_adr_i      (rd_adr),
    .rd_dat_o      (rd_dat),
    .wr_en_i       (wr_en),
    .wr_adr_i      (wr_adr),
    .wr_dat_i      (wr_dat),
    .ctx_req_i     (ctx_req),
    .ctx_clone_i   (ctx_clone),
    .ctx_target_i  (ctx_target),
    .ctx_busy_o    (ctx_busy),
    .ctx_ack_o     (ctx_ack),
    .active_bank_o (active_bank),
    .tap_dat_o     (tap_dat),
    .tap_upd_o     (tap_upd)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rd_en = 1'b0; rd_adr = '0; wr_en = 1'b0; wr_adr = '0; wr_dat = '0;
    ctx_req = 1'b0; ctx_clone = 1'b0; ctx_target = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eupd;
    logic [31:0] t0;
    logic [31:0] t1;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic re, input logic [4:0] a0, input logic [4:0] a1,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [1:0] eupd, input logic [31:0] t0,
                              input logic [31:0] t1);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.a0 = a0; v.a1 = a1;
    v.e0 = e0; v.e1 = e1; v.eupd = eupd; v.t0 = t0; v.t1 = t1;
    return v;
  endfunction

  // Reference model state
  logic [31:0] mdl [2][WORDS];
  logic [4:0]  m_held [2];
  logic [31:0] m_rd [2];
  int          m_active;
  int          m_tgt;
  int          copy_left;
  logic        m_ack;

  initial begin
    vec_t tbl[9];
    int   busy_cnt;
    int   ack_at;

    quiet();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rd_dat", rd_dat[31:0] | rd_dat[63:32], 32'd0);
    chk("rst_active", 32'(active_bank), 32'd0);
    chk("rst_busy", 32'(ctx_busy), 32'd0);
    chk("rst_ack", 32'(ctx_ack), 32'd0);
    chk("rst_tap_upd", 32'(tap_upd), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // ---- table-driven basic read/write/tap vectors ----
    tbl[0] = mk(1, 5,  32'hDEADBEEF, 0, 0, 0, 32'h0,        32'h0,        2'b00, 32'h0,    32'h0);
    tbl[1] = mk(0, 0,  32'h0,        1, 5, 0, 32'hDEADBEEF, 32'h0,        2'b00, 32'h0,    32'h0);
    tbl[2] = mk(1, 0,  32'd1234,     1, 0, 5, 32'h0,        32'hDEADBEEF, 2'b00, 32'h0,    32'h0);
    tbl[3] = mk(1, 7,  32'hA5A5A5A5, 1, 0, 7, 32'h0,        32'hA5A5A5A5, 2'b00, 32'h0,    32'h0);
    tbl[4] = mk(1, 7,  32'h1,        0, 0, 0, 32'h0,        32'h1,        2'b00, 32'h0,    32'h0);
    tbl[5] = mk(1, 9,  32'h1000,     0, 0, 0, 32'h0,        32'h1,        2'b01, 32'h1000, 32'h0);
    tbl[6] = mk(1, 20, 32'h55,       0, 0, 0, 32'h0,        32'h1,        2'b10, 32'h1000, 32'h55);
    tbl[7] = mk(1, 8,  32'h77,       0, 0, 0, 32'h0,        32'h1,        2'b00, 32'h1000, 32'h55);
    tbl[8] = mk(0, 0,  32'h0,        1, 9, 20, 32'h1000,    32'h55,       2'b00, 32'h1000, 32'h55);

    for (int i = 0; i < 9; i++) begin
      wr_en = tbl[i].we; wr_adr = tbl[i].wa; wr_dat = tbl[i].wd;
      rd_en = tbl[i].re; rd_adr = {tbl[i].a1, tbl[i].a0};
      #1;
      chk($sformatf("tbl%0d_tap_upd", i), 32'(tap_upd), 32'(tbl[i].eupd));
      step();
      chk($sformatf("tbl%0d_rd0", i), rd_dat[31:0], tbl[i].e0);
      chk($sformatf("tbl%0d_rd1", i), rd_dat[63:32], tbl[i].e1);
      chk($sformatf("tbl%0d_tap0", i), tap_dat[31:0], tbl[i].t0);
      chk($sformatf("tbl%0d_tap1", i), tap_dat[63:32], tbl[i].t1);
      $display("vec %0d: wr=%0b r%0d=%h rd=%0b a0=%0d a1=%0d -> %h %h", i,
               tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].a0, tbl[i].a1,
               rd_dat[31:0], rd_dat[63:32]);
    end
    quiet();

    // ---- clone bank 0 into bank 1 with writes during the walk ----
    for (int i = 1; i < WORDS; i++) begin
      wr_en = 1'b1; wr_adr = 5'(i); wr_dat = 32'(i);
      step();
    end
    quiet();
    ctx_req = 1'b1; ctx_clone = 1'b1; ctx_target = 1'b1;
    step();
    ctx_req = 1'b0;
    busy_cnt = 0;
    ack_at   = 0;
    for (int n = 1; n <= 40 && ack_at == 0; n++) begin
      if (ctx_busy) busy_cnt++;
      if (ctx_ack) ack_at = n;
      else begin
        // copy idx c is in flight at n == c+1
        wr_en  = (n == 4 || n == 11 || n == 13);
        wr_adr = (n == 13) ? 5'd12 : 5'd3;
        wr_dat = (n == 13) ? 32'hBEEF0012 : 32'hCAFE;
        ctx_req = (n == 6); ctx_clone = 1'b1; ctx_target = 1'b0;
        step();
      end
    end
    quiet();
    chk("clone_busy_cycles", 32'(busy_cnt), 32'd32);
    chk("clone_ack_cycle", 32'(ack_at), 32'd33);
    chk("clone_active", 32'(active_bank), 32'd1);
    $display("clone 0->1: busy=%0d ack_at=%0d active=%0d", busy_cnt, ack_at, active_bank);
    step();
    chk("clone_ack_one_cycle", 32'(ctx_ack), 32'd0);
    step();
    chk("busy_req_ignored", 32'(active_bank), 32'd1);
    chk("busy_req_no_ack", 32'(ctx_ack | ctx_busy), 32'd0);
    rd_en = 1'b1; rd_adr = {5'd3, 5'd17};
    step();
    chk("bank1_r17", rd_dat[31:0], 32'd17);
    chk("bank1_r3", rd_dat[63:32], 32'hCAFE);
    rd_adr = {5'd5, 5'd12};
    step();
    chk("bank1_r12_mirror", rd_dat[31:0], 32'hBEEF0012);
    chk("bank1_r5", rd_dat[63:32], 32'd5);
    quiet();
    ctx_req = 1'b1; ctx_clone = 1'b0; ctx_target = 1'b0;
    step();
    quiet();
    chk("switch_ack", 32'(ctx_ack), 32'd1);
    chk("switch_active", 32'(active_bank), 32'd0);
    chk("switch_busy", 32'(ctx_busy), 32'd0);
    $display("switch 1->0: ack=%0b active=%0d", ctx_ack, active_bank);
    step();
    chk("switch_ack_clear", 32'(ctx_ack), 32'd0);
    rd_en = 1'b1; rd_adr = {5'd12, 5'd3};
    step();
    chk("bank0_r3", rd_dat[31:0], 32'hCAFE);
    chk("bank0_r12", rd_dat[63:32], 32'hBEEF0012);
    quiet();

    // ---- reset in the middle of a clone ----
    ctx_req = 1'b1; ctx_clone = 1'b1; ctx_target = 1'b1;
    step();
    quiet();
    for (int n = 0; n < 12; n++) step();
    chk("midcopy_busy_before", 32'(ctx_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midcopy_rst_busy", 32'(ctx_busy), 32'd0);
    chk("midcopy_rst_active", 32'(active_bank), 32'd0);
    chk("midcopy_rst_ack", 32'(ctx_ack), 32'd0);
    step(); step();
    rst_n = 1'b1;
    rd_en = 1'b1; rd_adr = {5'd3, 5'd17};
    for (int n = 0; n < 4; n++) begin
      step();
      chk($sformatf("postrst_ack%0d", n), 32'(ctx_ack), 32'd0);
    end
    chk("postrst_r17", rd_dat[31:0], 32'd0);
    chk("postrst_r3", rd_dat[63:32], 32'd0);
    chk("postrst_tap", tap_dat[31:0] | tap_dat[63:32], 32'd0);
    $display("reset mid-clone: busy=%0b active=%0d", ctx_busy, active_bank);
    quiet();

    // ---- randomized traffic against the reference model ----
    for (int b = 0; b < 2; b++)
      for (int w = 0; w < WORDS; w++)
        mdl[b][w] = '0;
    m_held[0] = 5'd17; m_held[1] = 5'd3;
    m_rd[0] = '0; m_rd[1] = '0;
    m_active = 0; m_tgt = 0; copy_left = 0; m_ack = 1'b0;

    for (int it = 0; it < 600; it++) begin
      logic [4:0] a [2];
      logic       wok;
      logic       new_ack;
      wr_en  = ($urandom_range(0, 1) == 1);
      wr_adr = 5'($urandom_range(0, 31));
      wr_dat = $urandom;
      rd_en  = ($urandom_range(0, 2) == 0);
      for (int p = 0; p < 2; p++)
        a[p] = ($urandom_range(0, 3) == 0) ? wr_adr : 5'($urandom_range(0, 31));
      rd_adr = {a[1], a[0]};
      ctx_req    = ($urandom_range(0, 15) == 0);
      ctx_clone  = ($urandom_range(0, 1) == 1);
      ctx_target = 1'($urandom_range(0, 1));
      #1;
      chk("rnd_tap_upd", 32'(tap_upd),
          32'({wr_en && wr_adr == 5'd20, wr_en && wr_adr == 5'd9}));

      wok = wr_en && (wr_adr != 5'd0);
      for (int p = 0; p < 2; p++) begin
        if (rd_en) begin
          m_held[p] = a[p];
          if (a[p] == 5'd0)                 m_rd[p] = '0;
          else if (wok && wr_adr == a[p])   m_rd[p] = wr_dat;
          else                              m_rd[p] = mdl[m_active][a[p]];
        end else if (wok && wr_adr == m_held[p]) begin
          m_rd[p] = wr_dat;
        end
      end
      if (wok) mdl[m_active][wr_adr] = wr_dat;
      // A finished clone leaves the target identical to the active bank.
      new_ack = 1'b0;
      if (copy_left > 0) begin
        copy_left--;
        if (copy_left == 0) begin
          for (int w = 0; w < WORDS; w++) mdl[m_tgt][w] = mdl[m_active][w];
          m_active = m_tgt;
          new_ack  = 1'b1;
        end
      end else if (!m_ack && ctx_req) begin
        if (ctx_clone && int'(ctx_target) != m_active) begin
          copy_left = WORDS;
          m_tgt     = int'(ctx_target);
        end else begin
          m_active = int'(ctx_target);
          new_ack  = 1'b1;
        end
      end
      m_ack = new_ack;

      step();
      chk("rnd_rd0", rd_dat[31:0], m_rd[0]);
      chk("rnd_rd1", rd_dat[63:32], m_rd[1]);
      chk("rnd_tap0", tap_dat[31:0], mdl[m_active][9]);
      chk("rnd_tap1", tap_dat[63:32], mdl[m_active][20]);
      chk("rnd_busy", 32'(ctx_busy), 32'(copy_left > 0));
      chk("rnd_ack", 32'(ctx_ack), 32'(m_ack));
      chk("rnd_active", 32'(active_bank), 32'(m_active));
      if (m_ack)
        $display("rnd ctx ack: active=%0d dut=%0d", m_active, active_bank);
    end
    quiet();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
